// File: rtl/mux_scan_pkg.sv
// Shared types and default parameters for the mux select/capture sequencer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

    localparam int unsigned N_INPUTS_DEF      = 8;
    localparam int unsigned SETTLE_CYCLES_DEF = 1;

endpackage

// File: rtl/mux_8to1.sv
// Plain combinational 8:1 multiplexer that the scan controller walks through.
module mux_8to1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through every input, samples each after a settle
// window, and hands the assembled word downstream over valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_INPUTS      = N_INPUTS_DEF,
    parameter int unsigned SEL_W         = $clog2(N_INPUTS),
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                mux_out,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic [N_INPUTS-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [N_INPUTS-1:0] r_asm;
    logic [N_INPUTS-1:0] w_asm_nxt;
    logic [N_INPUTS-1:0] r_data_out;
    logic [N_INPUTS-1:0] w_data_out_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_data_valid;
    logic                w_data_valid_nxt;
    logic                w_settle_done;
    logic                w_last_sel;
    logic                w_handshake;

    assign w_settle_done = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_last_sel    = (r_sel == SEL_W'(N_INPUTS - 1));
    assign w_handshake   = r_data_valid && data_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks sample completion, DONE ignores abort.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)              w_state_nxt = ST_IDLE;
                else if (w_settle_done) w_state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)           w_state_nxt = ST_IDLE;
                else if (w_last_sel) w_state_nxt = ST_DONE;
                else                 w_state_nxt = ST_SETTLE;
            end
            ST_DONE: begin
                if (w_handshake) w_state_nxt = start ? ST_SETTLE : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output next values; sel only moves on sample, abort or idle.
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_sel_nxt        = r_sel;
        w_asm_nxt        = r_asm;
        w_data_out_nxt   = r_data_out;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_sel_nxt = '0;
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_cnt_nxt = '0;
                    w_sel_nxt = '0;
                end else if (w_settle_done) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                w_cnt_nxt = '0;
                if (abort) begin
                    w_sel_nxt = '0;
                end else begin
                    w_asm_nxt[r_sel] = mux_out;
                    if (w_last_sel) begin
                        w_data_out_nxt = {mux_out, r_asm[N_INPUTS-2:0]};
                        w_sel_nxt      = '0;
                    end else begin
                        w_sel_nxt = r_sel + SEL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_cnt_nxt = '0;
                w_sel_nxt = '0;
            end
            default: begin
                w_cnt_nxt = '0;
                w_sel_nxt = '0;
            end
        endcase
        w_busy_nxt       = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
        w_data_valid_nxt = (w_state_nxt == ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_sel        <= '0;
            r_asm        <= '0;
            r_data_out   <= '0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_asm        <= w_asm_nxt;
            r_data_out   <= w_data_out_nxt;
            r_busy       <= w_busy_nxt;
            r_data_valid <= w_data_valid_nxt;
        end
    end

    assign sel        = r_sel;
    assign busy       = r_busy;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl driving a real mux_8to1.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       data_ready;
    logic [7:0] r_mux_in;
    logic       w_mux_out;
    logic [2:0] w_sel;
    logic       w_busy;
    logic [7:0] w_data_out;
    logic       w_data_valid;

    int n_cmp;
    int n_err;

    mux_8to1 u_mux (
        .in  (r_mux_in),
        .sel (w_sel),
        .out (w_mux_out)
    );

    mux_scan_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mux_out    (w_mux_out),
        .sel        (w_sel),
        .busy       (w_busy),
        .data_out   (w_data_out),
        .data_valid (w_data_valid),
        .data_ready (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns right after the accepting edge.
    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts edges until data_valid rises, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!w_data_valid && n < 64) begin
            step();
            n++;
        end
    endtask

    int  lat;
    logic seen_valid;

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        data_ready = 1'b1;
        r_mux_in   = 8'hA5;
        step();
        step();
        chk("rst_sel",   32'(w_sel), 0);
        chk("rst_busy",  32'(w_busy), 0);
        chk("rst_valid", 32'(w_data_valid), 0);
        chk("rst_data",  32'(w_data_out), 0);
        rst_n = 1'b1;
        step();

        // Scan of A5 with per-cycle select check.
        kick();
        for (int k = 0; k < 16; k++) begin
            chk("sel_seq",    32'(w_sel), 32'(k / 2));
            chk("busy_scan",  32'(w_busy), 1);
            chk("valid_scan", 32'(w_data_valid), 0);
            step();
        end
        chk("a5_valid", 32'(w_data_valid), 1);
        chk("a5_data",  32'(w_data_out), 32'h A5);
        chk("a5_sel",   32'(w_sel), 0);
        chk("a5_busy",  32'(w_busy), 0);
        step();
        chk("a5_pulse", 32'(w_data_valid), 0);
        chk("a5_idle_sel", 32'(w_sel), 0);

        // Stalled downstream holds the word; start during stall ignored.
        r_mux_in   = 8'h3C;
        data_ready = 1'b0;
        kick();
        wait_valid(lat);
        chk("3c_latency", 32'(lat), 16);
        chk("3c_data", 32'(w_data_out), 32'h3C);
        r_mux_in = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            start = k[0];
            step();
            chk("stall_valid", 32'(w_data_valid), 1);
            chk("stall_data",  32'(w_data_out), 32'h3C);
            chk("stall_busy",  32'(w_busy), 0);
        end

        // Back-to-back: handshake with start high launches the next scan.
        start      = 1'b1;
        data_ready = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_valid_drop", 32'(w_data_valid), 0);
        chk("b2b_busy",       32'(w_busy), 1);
        wait_valid(lat);
        chk("c3_latency", 32'(lat), 16);
        chk("c3_data",    32'(w_data_out), 32'hC3);
        step();
        chk("c3_handshake", 32'(w_data_valid), 0);
        chk("c3_idle_busy", 32'(w_busy), 0);

        // Abort mid-scan at cycle 7.
        r_mux_in = 8'h5A;
        kick();
        for (int k = 0; k < 6; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy",  32'(w_busy), 0);
        chk("abort_sel",   32'(w_sel), 0);
        chk("abort_valid", 32'(w_data_valid), 0);
        chk("abort_data",  32'(w_data_out), 32'hC3);
        seen_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen_valid = seen_valid | w_data_valid;
        end
        chk("abort_no_valid", 32'(seen_valid), 0);

        // Abort on the final sample edge.
        kick();
        for (int k = 0; k < 15; k++) step();
        chk("last_sample_sel", 32'(w_sel), 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_last_valid", 32'(w_data_valid), 0);
        chk("abort_last_busy",  32'(w_busy), 0);
        chk("abort_last_data",  32'(w_data_out), 32'hC3);
        step();
        chk("abort_last_valid2", 32'(w_data_valid), 0);

        // Abort while a word waits in DONE does not drop it.
        r_mux_in   = 8'h0F;
        data_ready = 1'b0;
        kick();
        wait_valid(lat);
        chk("0f_latency", 32'(lat), 16);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("done_abort_valid", 32'(w_data_valid), 1);
        chk("done_abort_data",  32'(w_data_out), 32'h0F);
        data_ready = 1'b1;
        step();
        chk("0f_handshake", 32'(w_data_valid), 0);

        // Asynchronous reset mid-scan, then a clean scan.
        r_mux_in = 8'hFF;
        kick();
        for (int k = 0; k < 9; k++) step();
        chk("pre_rst_busy", 32'(w_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sel",   32'(w_sel), 0);
        chk("async_busy",  32'(w_busy), 0);
        chk("async_valid", 32'(w_data_valid), 0);
        chk("async_data",  32'(w_data_out), 0);
        step();
        step();
        rst_n    = 1'b1;
        r_mux_in = 8'h96;
        step();
        kick();
        wait_valid(lat);
        chk("96_latency", 32'(lat), 16);
        chk("96_data",    32'(w_data_out), 32'h96);
        step();
        chk("96_handshake", 32'(w_data_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
